// File: rtl/stage3_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// stage3_fetch_sequencer
//
// Fetch stage of the 3-stage pipeline. Issues instruction-memory reads, owns
// the fetch->execute pipeline register (instr, pc, pc+4, valid), absorbs
// execute-side stalls with a 1-entry skid buffer and applies redirects
// (branch / jump / exception) coming back from execute. A response that
// belongs to a squashed address is thrown away.
//
// Ports
//   CLK, nRST    clock, synchronous active-low reset
//   imem_ren     read request (held until completion)
//   imem_addr    word-aligned read address (= fetch_pc)
//   imem_busy    read not complete; completes when imem_ren & !imem_busy
//   imem_rdata   read data, valid in the completion cycle
//   ex_stall     execute cannot take fe_* this cycle
//   ex_flush     redirect request, target on brj_addr
//   brj_addr     redirect target
//   halt         stop issuing new fetches (level)
//   fe_valid/fe_instr/fe_pc/fe_pc4   fetch->execute register
//   fe_state     FSM state for debug (RUN=0, SQUASH=1, HALT=2)
// ----------------------------------------------------------------------------
module stage3_fetch_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0200
) (
    input  logic            CLK,
    input  logic            nRST,
    output logic            imem_ren,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_busy,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            ex_stall,
    input  logic            ex_flush,
    input  logic [XLEN-1:0] brj_addr,
    input  logic            halt,
    output logic            fe_valid,
    output logic [XLEN-1:0] fe_instr,
    output logic [XLEN-1:0] fe_pc,
    output logic [XLEN-1:0] fe_pc4,
    output logic [1:0]      fe_state
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HALT   = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);

    // Redirect targets are always loaded word aligned.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    state_e          state_q,      state_d;
    logic [XLEN-1:0] fetch_pc_q,   fetch_pc_d;
    logic [XLEN-1:0] pending_pc_q, pending_pc_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q,    skid_pc_d;
    logic            fe_valid_q,   fe_valid_d;
    logic [XLEN-1:0] fe_instr_q,   fe_instr_d;
    logic [XLEN-1:0] fe_pc_q,      fe_pc_d;
    logic [XLEN-1:0] fe_pc4_q,     fe_pc4_d;

    logic ren;
    logic complete;
    logic fe_free;

    // SQUASH keeps the old request alive so the memory transaction is never
    // withdrawn; RUN only requests when the skid has room for the answer.
    assign ren      = (state_q == ST_SQUASH) | ((state_q == ST_RUN) & ~skid_valid_q);
    assign complete = ren & ~imem_busy;
    // Register may be overwritten when it is empty or execute takes it now.
    assign fe_free  = ~fe_valid_q | ~ex_stall;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        fe_valid_d   = fe_valid_q;
        fe_instr_d   = fe_instr_q;
        fe_pc_d      = fe_pc_q;
        fe_pc4_d     = fe_pc4_q;

        if (ex_flush) begin
            // Redirect beats stall and completion; the old path is dropped.
            fe_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
            if (ren & imem_busy) begin
                // Cannot abandon the in-flight read: remember the target and
                // wait for the stale response in SQUASH.
                pending_pc_d = align_word(brj_addr);
                state_d      = ST_SQUASH;
            end else begin
                fetch_pc_d = align_word(brj_addr);
                state_d    = halt ? ST_HALT : ST_RUN;
            end
        end else begin
            // Only RUN responses carry live instructions; SQUASH data is stale.
            if (fe_free) begin
                if (skid_valid_q) begin
                    fe_valid_d   = 1'b1;
                    fe_instr_d   = skid_instr_q;
                    fe_pc_d      = skid_pc_q;
                    fe_pc4_d     = skid_pc_q + WORD_BYTES;
                    skid_valid_d = 1'b0;
                end else if (complete && (state_q == ST_RUN)) begin
                    fe_valid_d = 1'b1;
                    fe_instr_d = imem_rdata;
                    fe_pc_d    = fetch_pc_q;
                    fe_pc4_d   = fetch_pc_q + WORD_BYTES;
                end else begin
                    fe_valid_d = 1'b0;
                end
            end else if (complete && (state_q == ST_RUN)) begin
                skid_valid_d = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pc_d    = fetch_pc_q;
            end

            unique case (state_q)
                ST_RUN: begin
                    if (complete) begin
                        fetch_pc_d = fetch_pc_q + WORD_BYTES;
                    end
                    // An in-flight read finishes before halting.
                    if (halt && (!ren || complete)) begin
                        state_d = ST_HALT;
                    end
                end
                ST_SQUASH: begin
                    if (complete) begin
                        fetch_pc_d = pending_pc_q;
                        state_d    = halt ? ST_HALT : ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (!halt) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= ST_RUN;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            fe_valid_q   <= 1'b0;
            fe_instr_q   <= '0;
            fe_pc_q      <= '0;
            fe_pc4_q     <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            fe_valid_q   <= fe_valid_d;
            fe_instr_q   <= fe_instr_d;
            fe_pc_q      <= fe_pc_d;
            fe_pc4_q     <= fe_pc4_d;
        end
    end

    assign imem_ren  = ren;
    assign imem_addr = fetch_pc_q;
    assign fe_valid  = fe_valid_q;
    assign fe_instr  = fe_instr_q;
    assign fe_pc     = fe_pc_q;
    assign fe_pc4    = fe_pc4_q;
    assign fe_state  = state_q;

endmodule

// File: tb/tb_stage3_fetch_sequencer.sv
module tb_stage3_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        imem_busy;
    logic [31:0] imem_rdata;
    logic        ex_stall;
    logic        ex_flush;
    logic [31:0] brj_addr;
    logic        halt;
    logic        fe_valid;
    logic [31:0] fe_instr;
    logic [31:0] fe_pc;
    logic [31:0] fe_pc4;
    logic [1:0]  fe_state;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    stage3_fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0200)) dut (
        .CLK(CLK), .nRST(nRST),
        .imem_ren(imem_ren), .imem_addr(imem_addr), .imem_busy(imem_busy),
        .imem_rdata(imem_rdata),
        .ex_stall(ex_stall), .ex_flush(ex_flush), .brj_addr(brj_addr), .halt(halt),
        .fe_valid(fe_valid), .fe_instr(fe_instr), .fe_pc(fe_pc), .fe_pc4(fe_pc4),
        .fe_state(fe_state)
    );

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    // Reference model: fetch pointer, mode, redirect target, and an ordered
    // queue of delivered instructions awaiting execute (head = fe register).
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ins_t;

    ins_t        pipe[$];
    int          m_mode;   // 0 run, 1 squash, 2 halt
    logic [31:0] m_fpc;
    logic [31:0] m_pend;

    function automatic logic m_ren();
        return (m_mode == 1) || (m_mode == 0 && pipe.size() < 2);
    endfunction

    task automatic model_update();
        logic r;
        logic comp;
        r = m_ren();
        comp = r && !imem_busy;
        if (!nRST) begin
            pipe.delete();
            m_mode = 0;
            m_fpc  = 32'h200;
            m_pend = 32'h0;
        end else if (ex_flush) begin
            pipe.delete();
            if (r && imem_busy) begin
                m_pend = brj_addr & ~32'h3;
                m_mode = 1;
            end else begin
                m_fpc  = brj_addr & ~32'h3;
                m_mode = halt ? 2 : 0;
            end
        end else begin
            if (pipe.size() > 0 && !ex_stall) void'(pipe.pop_front());
            if (m_mode == 0) begin
                if (comp) begin
                    pipe.push_back('{pc: m_fpc, instr: mem_word(m_fpc)});
                    m_fpc = m_fpc + 32'd4;
                end
                if (halt && (!r || comp)) m_mode = 2;
            end else if (m_mode == 1) begin
                if (comp) begin
                    m_fpc  = m_pend;
                    m_mode = halt ? 2 : 0;
                end
            end else begin
                if (!halt) m_mode = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ren",   32'(imem_ren), 32'(m_ren()));
        chk("addr",  imem_addr, m_fpc);
        chk("valid", 32'(fe_valid), 32'(pipe.size() > 0));
        chk("state", 32'(fe_state), 32'(m_mode));
        if (pipe.size() > 0) begin
            chk("fe_pc",    fe_pc,    pipe[0].pc);
            chk("fe_pc4",   fe_pc4,   pipe[0].pc + 32'd4);
            chk("fe_instr", fe_instr, pipe[0].instr);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        check_all();
    endtask

    initial begin
        nRST = 1'b0; imem_busy = 1'b0; ex_stall = 1'b0; ex_flush = 1'b0;
        brj_addr = 32'h0; halt = 1'b0;
        m_mode = 0; m_fpc = 32'h200; m_pend = 32'h0;

        // Reset state
        step(); step();
        chk("rst_valid", 32'(fe_valid), 32'h0);
        chk("rst_pc",    fe_pc,    32'h0);
        chk("rst_pc4",   fe_pc4,   32'h0);
        chk("rst_instr", fe_instr, 32'h0);

        // 1: streaming from reset
        nRST = 1'b1;
        chk("t1_ren0",  32'(imem_ren), 32'h1);
        chk("t1_addr0", imem_addr, 32'h200);
        step();
        chk("t1_addr1", imem_addr, 32'h204);
        chk("t1_pc0",   fe_pc,     32'h200);
        chk("t1_pc4_0", fe_pc4,    32'h204);
        chk("t1_vld0",  32'(fe_valid), 32'h1);
        step();
        chk("t1_addr2", imem_addr, 32'h208);
        chk("t1_pc1",   fe_pc,     32'h204);

        // 2: stall with skid capture
        ex_stall = 1'b1;
        step(); step(); step();
        chk("t2_hold_pc", fe_pc, 32'h204);
        chk("t2_ren_off", 32'(imem_ren), 32'h0);
        ex_stall = 1'b0;
        step();
        chk("t2_drain_pc", fe_pc, 32'h208);
        chk("t2_next_req", imem_addr, 32'h20C);
        chk("t2_ren_on",   32'(imem_ren), 32'h1);

        // 3: flush with an idle/completing memory
        ex_flush = 1'b1; brj_addr = 32'h1000;
        step();
        ex_flush = 1'b0;
        chk("t3_vld", 32'(fe_valid), 32'h0);
        chk("t3_addr", imem_addr, 32'h1000);
        step();
        chk("t3_pc", fe_pc, 32'h1000);

        // 4: flush while a read is in flight
        imem_busy = 1'b1;
        step();
        ex_flush = 1'b1; brj_addr = 32'h2000;
        step();
        ex_flush = 1'b0;
        chk("t4_state", 32'(fe_state), 32'h1);
        step(); step(); step();
        chk("t4_addr_hold", imem_addr, 32'h1004);
        imem_busy = 1'b0;
        step();
        chk("t4_discard", 32'(fe_valid), 32'h0);
        chk("t4_addr_new", imem_addr, 32'h2000);
        chk("t4_run", 32'(fe_state), 32'h0);
        step();
        chk("t4_pc", fe_pc, 32'h2000);

        // 5: flush + stall with register and skid full
        ex_stall = 1'b1;
        step();
        ex_flush = 1'b1; brj_addr = 32'h2400;
        step();
        ex_flush = 1'b0; ex_stall = 1'b0;
        chk("t5_vld", 32'(fe_valid), 32'h0);
        step();
        chk("t5_pc", fe_pc, 32'h2400);

        // 6: halt, flush while halted, resume; then reset mid-transaction
        halt = 1'b1;
        step();
        chk("t6_halt", 32'(fe_state), 32'h2);
        chk("t6_noreq", 32'(imem_ren), 32'h0);
        step();
        chk("t6_drain", 32'(fe_valid), 32'h0);
        ex_flush = 1'b1; brj_addr = 32'h3001;
        step();
        ex_flush = 1'b0;
        chk("t6_misalign", imem_addr, 32'h3000);
        halt = 1'b0;
        step();
        chk("t6_resume", imem_addr, 32'h3000);
        step();
        chk("t6_pc", fe_pc, 32'h3000);
        imem_busy = 1'b1;
        step();
        nRST = 1'b0;
        step();
        chk("t6_rst_vld", 32'(fe_valid), 32'h0);
        chk("t6_rst_addr", imem_addr, 32'h200);
        nRST = 1'b1; imem_busy = 1'b0;
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            nRST      = ($urandom_range(99) != 0);
            imem_busy = ($urandom_range(9) < 3);
            ex_stall  = ($urandom_range(9) < 3);
            ex_flush  = ($urandom_range(19) == 0);
            brj_addr  = $urandom;
            if ($urandom_range(15) == 0) halt = ~halt;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
